fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder.
- Owns the PC and drives a simple request/ready instruction-memory port.
- Holds the fetched instruction in an instruction register and presents `opcode` (`instr[31:26]`) to the decoder with a valid flag.
- Accepts stalls from downstream and PC redirects from branch/jump resolution.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_unit_pc_reg.sv | 37 +++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage and its downstream decoder.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        EMPTY = 2'd1,
        FULL  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// PC register with its next-PC mux, plus the pc_out+4 adder for branch targets.
module pc_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_e           sel,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [ADDR_W-1:0] base_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] pc_d;

    // Next-PC select; redirect targets are forced word-aligned, increments wrap.
    always_comb begin
        pc_d = pc;
        case (sel)
            PC_INC:   pc_d = pc + ADDR_W'(4);
            PC_REDIR: pc_d = redirect_pc & ~ADDR_W'(3);
            default:  pc_d = pc;
        endcase
    end

    // PC register, reloaded to the boot vector on reset.
    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_d;
    end

    assign pc_plus4 = base_pc + ADDR_W'(4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem request/ready handshake and
// the instruction register feeding the decoder.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request, inputs ignored
// EMPTY | no live instruction, requesting imem_addr
// FULL  | instr/pc_out live; requesting the next word unless stalled
module fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               instr_valid
);

    fetch_state_e state_q, state_d;
    pc_sel_e      pc_sel;
    logic         accept;
    logic [ADDR_W-1:0] pc;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .sel         (pc_sel),
        .redirect_pc (redirect_pc),
        .base_pc     (pc_out),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // Next state, request and PC select; a redirect abandons any pending request.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        accept   = 1'b0;
        pc_sel   = PC_HOLD;
        case (state_q)
            BOOT: begin
                state_d = EMPTY;
            end
            EMPTY: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    pc_sel = PC_REDIR;
                end else if (imem_ready) begin
                    accept  = 1'b1;
                    pc_sel  = PC_INC;
                    state_d = FULL;
                end
            end
            FULL: begin
                imem_req = ~stall;
                if (redirect_valid) begin
                    pc_sel  = PC_REDIR;
                    state_d = EMPTY;
                end else if (!stall) begin
                    if (imem_ready) begin
                        accept = 1'b1;
                        pc_sel = PC_INC;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Instruction register and its address, loaded on every accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr  <= '0;
            pc_out <= '0;
        end else if (accept) begin
            instr  <= imem_rdata;
            pc_out <= pc;
        end
    end

    assign imem_addr   = pc;
    assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
    assign instr_valid = (state_q == FULL);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    int tests = 0;
    int fails = 0;
    bit scramble = 1'b0;
    bit checking = 1'b0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .instr          (instr),
        .opcode         (opcode),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .instr_valid    (instr_valid)
    );

    always #5 clk = ~clk;

    // Memory content: word = address, or a scrambled word so opcodes vary.
    assign imem_rdata = scramble ? ((imem_addr * 32'h9E37_79B1) ^ 32'h1234_5678) : imem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return scramble ? ((a * 32'h9E37_79B1) ^ 32'h1234_5678) : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "booting" after reset, "have" a live instruction or not.
    bit          m_boot;
    bit          m_have;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;

    always @(posedge clk) begin
        bit wants;
        if (rst) begin
            m_boot  = 1'b1;
            m_have  = 1'b0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_pcout = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            wants = !m_have || !stall;
            if (redirect_valid) begin
                m_pc   = {redirect_pc[31:2], 2'b00};
                m_have = 1'b0;
            end else if (wants && imem_ready) begin
                m_instr = mem_word(m_pc);
                m_pcout = m_pc;
                m_pc    = m_pc + 32'd4;
                m_have  = 1'b1;
            end else if (wants) begin
                m_have = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, (!m_boot && (!m_have || !stall))});
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            if (m_have || m_boot) begin
                chk("instr", instr, m_instr);
                chk("pc_out", pc_out, m_pcout);
            end
            if (m_have) begin
                chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
                chk("pc_plus4", pc_plus4, m_pcout + 32'd4);
            end
        end
    end

    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        // Reset, then ready tied high, stall low, word = address.
        cycle(2);
        checking = 1'b1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        chk("boot_instr", instr, 32'h0);
        rst = 1'b0;
        cycle();
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", {31'b0, instr_valid}, 32'd0);
        cycle();
        chk("seq0_valid", {31'b0, instr_valid}, 32'd1);
        chk("seq0_instr", instr, 32'h0);
        chk("seq0_addr", imem_addr, 32'h4);
        cycle();
        chk("seq1_instr", instr, 32'h4);
        chk("seq1_pcout", pc_out, 32'h4);

        // Stall two cycles holding pc_out=0x4.
        stall = 1'b1;
        cycle(2);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_instr", instr, 32'h4);
        chk("stall_pc", imem_addr, 32'h8);
        stall = 1'b0;
        cycle();
        chk("unstall_instr", instr, 32'h8);
        chk("unstall_pcout", pc_out, 32'h8);

        // Redirect back to 0x8, then ready low three cycles.
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        cycle();
        redirect_valid = 1'b0;
        imem_ready = 1'b0;
        chk("wait_valid", {31'b0, instr_valid}, 32'd0);
        cycle(3);
        chk("wait_addr", imem_addr, 32'h8);
        chk("wait_valid2", {31'b0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        cycle();
        chk("ready_instr", instr, 32'h8);
        chk("ready_pcplus4", pc_plus4, 32'hC);

        // Redirect with stall and ready in the same cycle.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        stall = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        cycle();
        chk("redir_pcout", pc_out, 32'h100);

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("wrap_pcout", pc_out, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pcplus4", pc_plus4, 32'h0);

        // Reset while a fetch at 0x40 is pending with ready high.
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        chk("pend_addr", imem_addr, 32'h40);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        cycle(2);
        chk("rst_after_pcout", pc_out, 32'h0);

        // Randomized traffic.
        scramble = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall          = ($urandom_range(0, 99) < 30);
            imem_ready     = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 10);
            redirect_pc    = $urandom;
            rst            = ($urandom_range(0, 99) < 1);
            cycle();
        end
        rst = 1'b0;
        cycle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
